// File: rtl/axis_arbiter_if.sv
// axis_arbiter_if: AXI4-Stream beat channel (tvalid/tlast/tdata/tready).
//   master modport drives tvalid/tlast/tdata and receives tready;
//   slave modport receives tvalid/tlast/tdata and drives tready.
interface axis_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tready;
  modport master (output tvalid, tlast, tdata, input tready);
  modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/axis_arbiter.sv
// axis_arbiter: two-input round-robin per-packet AXI4-Stream arbiter merging a and b onto k.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   a, b  : slave streams competing for the output
//   k     : master stream, combinationally steered from the granted source
module axis_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  axis_arbiter_if.slave  a,
  axis_arbiter_if.slave  b,
  axis_arbiter_if.master k
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;
  logic [1:0] state, state_nxt;
  logic       last_grant, last_nxt;
  logic       gnt_a, gnt_b, a_end, b_end;
  assign gnt_a = state == GNT_A;
  assign gnt_b = state == GNT_B;
  // a packet only ends when its tlast beat actually transfers
  assign a_end = gnt_a & a.tvalid & k.tready & a.tlast;
  assign b_end = gnt_b & b.tvalid & k.tready & b.tlast;
  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    if (state == IDLE)
      // on a tie the source that did not win last time is granted
      state_nxt = a.tvalid & (~b.tvalid | last_grant) ? GNT_A : b.tvalid ? GNT_B : IDLE;
    else if (a_end) begin
      last_nxt  = 1'b0;
      state_nxt = b.tvalid ? GNT_B : IDLE;
    end else if (b_end) begin
      last_nxt  = 1'b1;
      state_nxt = a.tvalid ? GNT_A : IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
    end
  assign k.tvalid = gnt_a ? a.tvalid : gnt_b & b.tvalid;
  assign k.tlast  = gnt_a ? a.tlast  : gnt_b & b.tlast;
  assign k.tdata  = gnt_a ? a.tdata  : gnt_b ? b.tdata : {DATA_WIDTH{1'b0}};
  assign a.tready = gnt_a & k.tready;
  assign b.tready = gnt_b & k.tready;
endmodule

// File: tb/tb_axis_arbiter.sv
// tb_axis_arbiter: directed and randomized checks of axis_arbiter against a packet-ownership model.
module tb_axis_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   owner;
  logic prefer_b;
  logic [11:0] got, exp;
  always #5 clk = ~clk;
  axis_arbiter_if #(.DATA_WIDTH(8)) ai ();
  axis_arbiter_if #(.DATA_WIDTH(8)) bi ();
  axis_arbiter_if #(.DATA_WIDTH(8)) ki ();
  axis_arbiter #(.DATA_WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (ai),
    .b    (bi),
    .k    (ki)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask
  // owner: 0 = nobody, 1 = A, 2 = B; prefer_b: B wins the next tie
  always @(posedge clk or negedge reset)
    if (!reset) begin
      owner    <= 0;
      prefer_b <= 1'b0;
    end else if (owner == 0)
      owner <= ai.tvalid && (!bi.tvalid || !prefer_b) ? 1 : bi.tvalid ? 2 : 0;
    else if (owner == 1 && ai.tvalid && ki.tready && ai.tlast) begin
      prefer_b <= 1'b1;
      owner    <= bi.tvalid ? 2 : 0;
    end else if (owner == 2 && bi.tvalid && ki.tready && bi.tlast) begin
      prefer_b <= 1'b0;
      owner    <= ai.tvalid ? 1 : 0;
    end
  always @(negedge clk)
    if (cmp_en) begin
      exp = owner == 1 ? {ai.tvalid, ai.tlast, ai.tdata, ki.tready, 1'b0} :
            owner == 2 ? {bi.tvalid, bi.tlast, bi.tdata, 1'b0, ki.tready} : 12'h0;
      got = {ki.tvalid, ki.tlast, ki.tdata, ai.tready, bi.tready};
      chk("model_outputs", {20'h0, got}, {20'h0, exp});
    end
  initial begin
    reset = 1'b0;
    ai.tvalid = 1'b1; ai.tlast = 1'b0; ai.tdata = 8'h55;
    bi.tvalid = 1'b1; bi.tlast = 1'b0; bi.tdata = 8'h0F;
    ki.tready = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_kvalid", {31'h0, ki.tvalid}, 0);
    chk("rst_kdata", {24'h0, ki.tdata}, 0);
    chk("rst_ardy", {31'h0, ai.tready}, 0);
    chk("rst_brdy", {31'h0, bi.tready}, 0);
    @(posedge clk); #1;
    reset = 1'b1; ai.tvalid = 1'b0; bi.tvalid = 1'b1; bi.tlast = 1'b1; ki.tready = 1'b0;
    @(negedge clk);
    chk("b_arb_kvalid", {31'h0, ki.tvalid}, 0);
    @(posedge clk); @(negedge clk);
    chk("b_kvalid", {31'h0, ki.tvalid}, 1);
    chk("b_kdata", {24'h0, ki.tdata}, 32'h0F);
    chk("b_stall_brdy", {31'h0, bi.tready}, 0);
    ki.tready = 1'b1; #1;
    chk("b_brdy", {31'h0, bi.tready}, 1);
    @(posedge clk); #1;
    bi.tvalid = 1'b0; bi.tlast = 1'b0;
    @(negedge clk);
    chk("b_done_kvalid", {31'h0, ki.tvalid}, 0);
    @(posedge clk); #1;
    ai.tvalid = 1'b1; ai.tlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ai.tlast = (i == 3);
      @(negedge clk);
      chk("a_kvalid", {31'h0, ki.tvalid}, 1);
      chk("a_kdata", {24'h0, ki.tdata}, 32'h55);
      chk("a_klast", {31'h0, ki.tlast}, {31'h0, i == 3});
      chk("a_ardy", {31'h0, ai.tready}, 1);
    end
    @(posedge clk); #1;
    ai.tvalid = 1'b0; ai.tlast = 1'b0;
    @(negedge clk);
    chk("a_done_kvalid", {31'h0, ki.tvalid}, 0);
    reset = 1'b0;
    ai.tvalid = 1'b1; ai.tlast = 1'b1;
    bi.tvalid = 1'b1; bi.tlast = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_kdata", {24'h0, ki.tdata}, i % 2 ? 32'h0F : 32'h55);
      chk("rr_brdy", {31'h0, bi.tready}, i % 2);
    end
    ki.tready = 1'b0; #1;
    chk("bp_brdy", {31'h0, bi.tready}, 0);
    @(posedge clk); @(negedge clk);
    chk("bp_kvalid", {31'h0, ki.tvalid}, 1);
    chk("bp_kdata", {24'h0, ki.tdata}, 32'h0F);
    #2 reset = 1'b0; #1;
    chk("abort_kvalid", {31'h0, ki.tvalid}, 0);
    chk("abort_kdata", {24'h0, ki.tdata}, 0);
    @(posedge clk); #1;
    reset = 1'b1; ki.tready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("restart_kdata", {24'h0, ki.tdata}, 32'h55);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset     = $urandom_range(0, 63) != 0;
      ai.tvalid = 1'($urandom);
      ai.tlast  = $urandom_range(0, 2) == 0;
      ai.tdata  = 8'($urandom);
      bi.tvalid = 1'($urandom);
      bi.tlast  = $urandom_range(0, 2) == 0;
      bi.tdata  = 8'($urandom);
      ki.tready = $urandom_range(0, 3) != 0;
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
